// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key count, FSM state type and key-vector predicates
package keypad_pkg;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  function automatic int unsigned popcount(input logic [NUM_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return popcount(v) == 1;
  endfunction

  function automatic logic is_multi(input logic [NUM_KEYS-1:0] v);
    return popcount(v) >= 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterized-width double-flop synchronizer, async active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debounce_e3.sv
// rtl/keypad_debounce_e3.sv - debounced one-hot keypad front end for cod_dec_E3
// Optional auto-repeat of tecla_valid while a key is held: KEYPAD_AUTOREPEAT_EN
module keypad_debounce_e3
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] tecla,
  output logic [NUM_KEYS-1:0] tecla_onehot,
  output logic                tecla_valid,
  output logic                multi_err
);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
    $error("keypad_debounce_e3: DEB_CYCLES must be 2..65535");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_rpt
    $error("keypad_debounce_e3: REPEAT_CYCLES must be >= 2");
  end

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_PRESS = CW'(DEB_CYCLES - 1);
  // Entering RELEASE already counts one zero sample, so the release run ends one step earlier.
  localparam logic [CW-1:0] CNT_REL   = CW'(DEB_CYCLES - 2);

  logic [NUM_KEYS-1:0] sync;
  kp_state_t           state_q, state_d;
  logic [NUM_KEYS-1:0] cand_q, cand_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] onehot_d;
  logic                valid_d;
  logic                rpt_fire;

  sync_2ff #(.WIDTH(NUM_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tecla),
    .q     (sync)
  );

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    onehot_d = tecla_onehot;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (is_onehot(sync)) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync == cand_q) begin
          if (cnt_q == CNT_PRESS) begin
            state_d  = PRESSED;
            onehot_d = cand_q;
            valid_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        onehot_d = cand_q;
        if (sync != cand_q) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        onehot_d = cand_q;
        if (sync == '0) begin
          if (cnt_q == CNT_REL) begin
            state_d  = IDLE;
            onehot_d = '0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (sync == cand_q) begin
          state_d = PRESSED;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_q, rpt_d;

  // Counter only advances while staying in PRESSED; any entry or exit leaves it at zero.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (state_q == PRESSED && state_d == PRESSED) begin
      if (rpt_q == RPT_MAX) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      tecla_onehot <= '0;
      tecla_valid  <= 1'b0;
      multi_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      tecla_onehot <= onehot_d;
      tecla_valid  <= valid_d | rpt_fire;
      multi_err    <= is_multi(sync);
    end
  end

endmodule

// File: tb/tb_keypad_debounce_e3.sv
// tb/tb_keypad_debounce_e3.sv - directed self-checking bench for keypad_debounce_e3
module tb_keypad_debounce_e3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tecla;
  logic [9:0] tecla_onehot;
  logic       tecla_valid;
  logic       multi_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [9:0] t;
    logic [9:0] oh;
    logic       v;
    logic       m;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  keypad_debounce_e3 #(.DEB_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tecla        (tecla),
    .tecla_onehot (tecla_onehot),
    .tecla_valid  (tecla_valid),
    .multi_err    (multi_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [9:0] t, input int n, input logic [9:0] oh, input logic v,
                     input logic m);
    vec_t r;
    r.t = t; r.oh = oh; r.v = v; r.m = m;
    for (int i = 0; i < n; i++) vecs.push_back(r);
  endtask

  // Drive at the falling edge, let one rising edge sample, look at outputs on the next fall.
  task automatic step(input logic [9:0] t);
    tecla = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  int first_pulse;
  int second_pulse;
  int pulses;
  int held;

  initial begin
    rst_n = 1'b0;
    tecla = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {20'd0, tecla_onehot, tecla_valid, multi_err}, 32'd0);
    rst_n = 1'b1;

    // Clean press of key 5, release, multi-key, single-cycle glitch.
    add(10'h020, 6, 10'h000, 1'b0, 1'b0);
    add(10'h020, 1, 10'h020, 1'b1, 1'b0);
    add(10'h020, 13, 10'h020, 1'b0, 1'b0);
    add(10'h000, 5, 10'h020, 1'b0, 1'b0);
    add(10'h000, 5, 10'h000, 1'b0, 1'b0);
    add(10'h005, 2, 10'h000, 1'b0, 1'b0);
    add(10'h005, 6, 10'h000, 1'b0, 1'b1);
    add(10'h000, 2, 10'h000, 1'b0, 1'b1);
    add(10'h000, 3, 10'h000, 1'b0, 1'b0);
    add(10'h080, 1, 10'h000, 1'b0, 1'b0);
    add(10'h000, 8, 10'h000, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].t);
      check($sformatf("vec%0d", i), {20'd0, tecla_onehot, tecla_valid, multi_err},
            {20'd0, vecs[i].oh, vecs[i].v, vecs[i].m});
    end

    // Press bounce on key 3: 12 cycles toggling every 2, then held; last rise at edge 13.
    pulses = 0; first_pulse = -1;
    for (int i = 1; i <= 30; i++) begin
      step((i <= 12) ? ((((i - 1) / 2) % 2 == 0) ? 10'h008 : 10'h000) : 10'h008);
      if (tecla_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_pulse_edge", first_pulse, 19);
    check("bounce_onehot", {22'd0, tecla_onehot}, 32'h008);
    for (int i = 0; i < 10; i++) step(10'h000);
    check("bounce_released", {22'd0, tecla_onehot}, 32'h000);

    // Release bounce on key 9: 0, 1, 0 then steady 0.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(10'h200);
      if (tecla_valid) pulses++;
    end
    check("k9_press_pulses", pulses, 1);
    pulses = 0; held = 0;
    for (int j = 0; j < 7; j++) begin
      step((j == 1) ? 10'h200 : 10'h000);
      if (tecla_valid) pulses++;
      if (tecla_onehot == 10'h200) held++;
    end
    check("relbounce_no_pulse", pulses, 0);
    check("relbounce_held", held, 7);
    step(10'h000);
    check("relbounce_cleared", {22'd0, tecla_onehot}, 32'h000);
    for (int i = 0; i < 4; i++) step(10'h000);

    // Asynchronous reset while key 1 is accepted; still held, so it is re-accepted at edge 7.
    for (int i = 0; i < 10; i++) step(10'h002);
    check("k1_accepted", {22'd0, tecla_onehot}, 32'h002);
    #2 rst_n = 1'b0;
    #1 check("async_reset_pressed", {20'd0, tecla_onehot, tecla_valid, multi_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; first_pulse = -1;
    for (int i = 1; i <= 12; i++) begin
      step(10'h002);
      if (tecla_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check("reaccept_pulses", pulses, 1);
    check("reaccept_edge", first_pulse, 7);
    for (int i = 0; i < 8; i++) step(10'h000);

    // Asynchronous reset while multi_err is high.
    for (int i = 0; i < 4; i++) step(10'h006);
    check("multi_before_reset", {31'd0, multi_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_multi", {20'd0, tecla_onehot, tecla_valid, multi_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(10'h000);

    // Hold key 0 for 40 cycles.
    pulses = 0; first_pulse = -1; second_pulse = -1;
    for (int i = 1; i <= 40; i++) begin
      step(10'h001);
      if (tecla_valid) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else if (second_pulse < 0) second_pulse = i;
      end
    end
    check("hold_first_edge", first_pulse, 7);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold_pulses", pulses, 5);
    check("hold_second_edge", second_pulse, 15);
`else
    check("hold_pulses", pulses, 1);
    check("hold_second_edge", second_pulse, -1);
`endif
    check("hold_onehot", {22'd0, tecla_onehot}, 32'h001);
    for (int i = 0; i < 8; i++) step(10'h000);
    check("hold_released", {22'd0, tecla_onehot}, 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
